// File: rtl/nanorv32_uart_ctrl.sv
// 8N1 UART peripheral for the nanorv32 peripheral bus: TX FIFO, single-entry RX
// holding register, programmable baud divisor (bit period = divisor + 1 clocks).
module nanorv32_uart_ctrl #(
    parameter int          PADDR_W      = 12,
    parameter int          TXFIFO_DEPTH = 4,
    parameter logic [15:0] DEFAULT_DIV  = 16'd433
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PADDR_W-1:0] bus_uart_addr,
    input  logic [3:0]         bus_uart_bytesel,
    input  logic [31:0]        bus_uart_din,
    input  logic               bus_uart_en,
    output logic [31:0]        uart_bus_dout,
    output logic               uart_bus_ready_nxt,
    output logic               uart_pad_tx,
    input  logic               pad_uart_rx,
    output logic               uart_irq
);
    localparam int AW = $clog2(TXFIFO_DEPTH);

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_BAUD   = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic [1:0]  reg_sel;
    logic        bus_wr, bus_rd, data_rd, status_w1c;
    logic [31:0] rdata;

    logic [3:0]  ctrl;
    logic [15:0] baud;
    logic        tx_en, rx_en, txie, rxie;
    logic        tx_ovf, rx_ovr, rx_valid;
    logic [7:0]  rx_byte;

    logic [7:0]  fifo_mem [TXFIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        fifo_full, fifo_empty, push_req, fifo_push, fifo_pop;

    tx_state_t   tx_state, tx_state_nxt;
    logic [15:0] tx_cnt, tx_cnt_nxt;
    logic [2:0]  tx_bit, tx_bit_nxt;
    logic [7:0]  tx_shift, tx_shift_nxt;
    logic        tx_out_nxt, tx_busy;

    rx_state_t   rx_state, rx_state_nxt;
    logic [15:0] rx_cnt, rx_cnt_nxt, rx_half_m1;
    logic [2:0]  rx_bit, rx_bit_nxt;
    logic [7:0]  rx_shift, rx_shift_nxt;
    logic [1:0]  rx_sync;
    logic        rx_s, rx_prev, rx_load;

    logic        unused_bits;
    assign unused_bits = ^{bus_uart_addr[PADDR_W-1:4], bus_uart_addr[1:0], bus_uart_din[31:16]};

    assign reg_sel            = bus_uart_addr[3:2];
    assign bus_wr             = bus_uart_en && (bus_uart_bytesel != 4'b0000);
    assign bus_rd             = bus_uart_en && (bus_uart_bytesel == 4'b0000);
    assign data_rd            = bus_rd && (reg_sel == REG_DATA);
    assign status_w1c         = bus_wr && (reg_sel == REG_STATUS) && bus_uart_bytesel[0];
    assign uart_bus_ready_nxt = bus_uart_en;

    assign {rxie, txie, rx_en, tx_en} = ctrl;
    assign uart_irq = (rx_valid & rxie) | (fifo_empty & txie);

    // ---------------------------------------------------------------- TX FIFO
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push_req   = bus_wr && (reg_sel == REG_DATA) && bus_uart_bytesel[0];
    assign fifo_push  = push_req && !fifo_full;

    // NOTE: FIFO storage has no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (fifo_push) fifo_mem[wr_ptr[AW-1:0]] <= bus_uart_din[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + {{AW{1'b0}}, fifo_push};
            rd_ptr <= rd_ptr + {{AW{1'b0}}, fifo_pop};
        end
    end

    // ---------------------------------------------------------- register file
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        rdata = '0;
        case (reg_sel)
            REG_DATA:   rdata = {24'b0, rx_byte};
            REG_STATUS: rdata = {26'b0, tx_ovf, rx_ovr, rx_valid, tx_busy, fifo_empty, fifo_full};
            REG_BAUD:   rdata = {16'b0, baud};
            REG_CTRL:   rdata = {28'b0, ctrl};
            default:    rdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl          <= '0;
            baud          <= DEFAULT_DIV;
            tx_ovf        <= 1'b0;
            rx_ovr        <= 1'b0;
            rx_valid      <= 1'b0;
            rx_byte       <= '0;
            uart_bus_dout <= '0;
        end else begin
            if (bus_rd) uart_bus_dout <= rdata;
            if (bus_wr && (reg_sel == REG_CTRL) && bus_uart_bytesel[0]) ctrl <= bus_uart_din[3:0];
            if (bus_wr && (reg_sel == REG_BAUD)) begin
                if (bus_uart_bytesel[0]) baud[7:0]  <= bus_uart_din[7:0];
                if (bus_uart_bytesel[1]) baud[15:8] <= bus_uart_din[15:8];
            end
            // Setting a sticky flag wins over a same-cycle write-one-to-clear.
            if (push_req && fifo_full)           tx_ovf <= 1'b1;
            else if (status_w1c && bus_uart_din[5]) tx_ovf <= 1'b0;
            if (rx_load && rx_valid && !data_rd) rx_ovr <= 1'b1;
            else if (status_w1c && bus_uart_din[4]) rx_ovr <= 1'b0;
            // A byte landing on the same edge as a DATA read keeps rx_valid set.
            if (rx_load)      rx_valid <= 1'b1;
            else if (data_rd) rx_valid <= 1'b0;
            if (rx_load) rx_byte <= rx_shift_nxt;
        end
    end

    // --------------------------------------------------------------- TX FSM
    assign tx_busy = (tx_state != TX_IDLE);

    always_comb begin
        tx_state_nxt = tx_state;
        tx_cnt_nxt   = tx_cnt;
        tx_bit_nxt   = tx_bit;
        tx_shift_nxt = tx_shift;
        tx_out_nxt   = uart_pad_tx;
        fifo_pop     = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                tx_out_nxt = 1'b1;
                if (tx_en && !fifo_empty) begin
                    tx_state_nxt = TX_START;
                    tx_cnt_nxt   = baud;
                    tx_shift_nxt = fifo_mem[rd_ptr[AW-1:0]];
                    fifo_pop     = 1'b1;
                    tx_out_nxt   = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt != 16'd0) begin
                    tx_cnt_nxt = tx_cnt - 16'd1;
                end else begin
                    tx_state_nxt = TX_DATA;
                    tx_cnt_nxt   = baud;
                    tx_bit_nxt   = 3'd0;
                    tx_out_nxt   = tx_shift[0];
                end
            end
            TX_DATA: begin
                if (tx_cnt != 16'd0) begin
                    tx_cnt_nxt = tx_cnt - 16'd1;
                end else begin
                    tx_cnt_nxt = baud;
                    if (tx_bit == 3'd7) begin
                        tx_state_nxt = TX_STOP;
                        tx_out_nxt   = 1'b1;
                    end else begin
                        tx_bit_nxt   = tx_bit + 3'd1;
                        tx_shift_nxt = {1'b0, tx_shift[7:1]};
                        tx_out_nxt   = tx_shift[1];
                    end
                end
            end
            TX_STOP: begin
                if (tx_cnt != 16'd0) begin
                    tx_cnt_nxt = tx_cnt - 16'd1;
                end else if (tx_en && !fifo_empty) begin
                    tx_state_nxt = TX_START;
                    tx_cnt_nxt   = baud;
                    tx_shift_nxt = fifo_mem[rd_ptr[AW-1:0]];
                    fifo_pop     = 1'b1;
                    tx_out_nxt   = 1'b0;
                end else begin
                    tx_state_nxt = TX_IDLE;
                    tx_out_nxt   = 1'b1;
                end
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state    <= TX_IDLE;
            tx_cnt      <= '0;
            tx_bit      <= '0;
            tx_shift    <= '0;
            uart_pad_tx <= 1'b1;
        end else begin
            tx_state    <= tx_state_nxt;
            tx_cnt      <= tx_cnt_nxt;
            tx_bit      <= tx_bit_nxt;
            tx_shift    <= tx_shift_nxt;
            uart_pad_tx <= tx_out_nxt;
        end
    end

    // --------------------------------------------------------------- RX FSM
    assign rx_s       = rx_sync[1];
    // (DIV+1)>>1 - 1 without a 17-bit intermediate.
    assign rx_half_m1 = (baud >> 1) - {15'b0, ~baud[0]};

    always_comb begin
        rx_state_nxt = rx_state;
        rx_cnt_nxt   = rx_cnt;
        rx_bit_nxt   = rx_bit;
        rx_shift_nxt = rx_shift;
        rx_load      = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rx_en && rx_prev && !rx_s) begin
                    rx_state_nxt = RX_START;
                    rx_cnt_nxt   = rx_half_m1;
                end
            end
            RX_START: begin
                if (rx_cnt != 16'd0) begin
                    rx_cnt_nxt = rx_cnt - 16'd1;
                end else if (rx_s) begin
                    rx_state_nxt = RX_IDLE;
                end else begin
                    rx_state_nxt = RX_DATA;
                    rx_cnt_nxt   = baud;
                    rx_bit_nxt   = 3'd0;
                end
            end
            RX_DATA: begin
                if (rx_cnt != 16'd0) begin
                    rx_cnt_nxt = rx_cnt - 16'd1;
                end else begin
                    rx_shift_nxt = {rx_s, rx_shift[7:1]};
                    rx_cnt_nxt   = baud;
                    if (rx_bit == 3'd7) rx_state_nxt = RX_STOP;
                    else                rx_bit_nxt   = rx_bit + 3'd1;
                end
            end
            RX_STOP: begin
                if (rx_cnt != 16'd0) begin
                    rx_cnt_nxt = rx_cnt - 16'd1;
                end else begin
                    rx_state_nxt = RX_IDLE;
                    rx_load      = rx_s;
                end
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sync  <= 2'b11;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_sync  <= {rx_sync[0], pad_uart_rx};
            rx_prev  <= rx_s;
            rx_state <= rx_state_nxt;
            rx_cnt   <= rx_cnt_nxt;
            rx_bit   <= rx_bit_nxt;
            rx_shift <= rx_shift_nxt;
        end
    end

endmodule
